// File: rtl/waveform_renderer_pkg.sv
`default_nettype none
// ============================================================================
// waveform_renderer_pkg
// Shared VGA geometry, colour constants and trace margin for the renderer.
// Revision: 1.0
// ============================================================================
package waveform_renderer_pkg;

  localparam int VGA_HOR_RES    = 640;
  localparam int VGA_VER_RES    = 480;
  localparam int RGB_W          = 12;
  localparam int MARGIN_DEFAULT = 4;

  typedef enum logic [RGB_W-1:0] {
    BACKGROUND = 12'h000,
    GRID       = 12'h444,
    TRACE      = 12'h0F0
  } colour_e;

endpackage
`default_nettype wire

// File: rtl/waveform_renderer_trace_pixel_classifier.sv
`default_nettype none
// ============================================================================
// trace_pixel_classifier
// Combinational colour decision for one pixel of a digital trace lane.
// Revision: 1.0
// ============================================================================
module trace_pixel_classifier
  import waveform_renderer_pkg::*;
#(
  parameter int ROW_W  = 9,
  parameter int CHN_W  = 4,
  parameter int MARGIN = MARGIN_DEFAULT
) (
  input  logic             valid_i,
  input  logic             b_i,
  input  logic             p_i,
  input  logic             first_col_i,
  input  logic [ROW_W-1:0] row_i,
  input  logic [ROW_W-1:0] offset_i,
  input  logic [ROW_W-1:0] height_i,
  input  logic [CHN_W-1:0] chan_i,
  output logic [RGB_W-1:0] colour_o
);

  // One extra bit so offset+height near the bottom of the screen cannot wrap.
  logic [ROW_W:0] row_x;
  logic [ROW_W:0] hi_row;
  logic [ROW_W:0] lo_row;
  logic           too_small;
  logic           lit;
  logic           separator;

  always_comb begin
    row_x     = {1'b0, row_i};
    hi_row    = {1'b0, offset_i} + (ROW_W+1)'(MARGIN);
    lo_row    = {1'b0, offset_i} + {1'b0, height_i} - (ROW_W+1)'(MARGIN + 1);
    too_small = {1'b0, height_i} < (ROW_W+1)'(2 * MARGIN + 2);
    lit       = (b_i && (row_x == hi_row)) ||
                (!b_i && (row_x == lo_row)) ||
                ((b_i != p_i) && first_col_i && (row_x >= hi_row) && (row_x <= lo_row));
    separator = (row_i == offset_i) && (chan_i != '0);
    colour_o  = BACKGROUND;
    if (valid_i && !too_small) begin
      if (lit) begin
        colour_o = TRACE;
      end else if (separator) begin
        colour_o = GRID;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/waveform_renderer.sv
`default_nettype none
// ============================================================================
// waveform_renderer
// 3-cycle pixel pipeline: sample RAM fetch, edge tracking and trace colouring.
// Revision: 1.0
// ============================================================================
module waveform_renderer
  import waveform_renderer_pkg::*;
#(
  parameter int MAX_CHAN_COUNT = 10,
  parameter int ADDR_W         = 10,
  parameter int H_RES          = VGA_HOR_RES,
  parameter int V_RES          = VGA_VER_RES,
  parameter int MARGIN         = MARGIN_DEFAULT,
  parameter int COLOR_W        = RGB_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pixel_valid_i,
  input  logic [$clog2(H_RES)-1:0]          pixel_col_i,
  input  logic [$clog2(V_RES)-1:0]          pixel_row_i,
  input  logic                              hsync_i,
  input  logic                              vsync_i,
  input  logic                              is_channel_i,
  input  logic [$clog2(MAX_CHAN_COUNT)-1:0] channel_number_i,
  input  logic [$clog2(V_RES)-1:0]          channel_height_i,
  input  logic [$clog2(V_RES)-1:0]          channel_offset_i,
  input  logic [2:0]                        zoom_shift_i,
  input  logic [ADDR_W-1:0]                 start_addr_i,
  output logic                              mem_rd_en_o,
  output logic [ADDR_W-1:0]                 mem_addr_o,
  input  logic [MAX_CHAN_COUNT-1:0]         mem_data_i,
  output logic [COLOR_W-1:0]                rgb_o,
  output logic                              hsync_o,
  output logic                              vsync_o,
  output logic                              pixel_valid_o
);

  localparam int COL_W = $clog2(H_RES);
  localparam int ROW_W = $clog2(V_RES);
  localparam int CHN_W = $clog2(MAX_CHAN_COUNT);

  typedef struct packed {
    logic             valid;
    logic             hsync;
    logic             vsync;
    logic             is_channel;
    logic             first_col;
    logic             col_zero;
    logic [COL_W-1:0] idx;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] height;
    logic [ROW_W-1:0] offset;
    logic [CHN_W-1:0] chan;
  } stage_t;

  stage_t                    s1_d, s1_q, s2_q;
  logic                      vsync_prev_q;
  logic [ADDR_W-1:0]         frame_base_q;
  logic [ADDR_W-1:0]         mem_addr_d, mem_addr_q;
  logic [MAX_CHAN_COUNT-1:0] cur_word_d, cur_word_q;
  logic [MAX_CHAN_COUNT-1:0] prev_word_d, prev_word_q;
  logic [COL_W-1:0]          last_idx_d, last_idx_q;
  logic [COL_W-1:0]          col_mask;
  logic [RGB_W-1:0]          colour;
  logic [COLOR_W-1:0]        rgb_q;
  logic                      hsync_q, vsync_q, valid_q;

  always_comb begin
    col_mask         = COL_W'((32'd1 << zoom_shift_i) - 32'd1);
    s1_d.valid       = pixel_valid_i;
    s1_d.hsync       = hsync_i;
    s1_d.vsync       = vsync_i;
    s1_d.is_channel  = is_channel_i;
    s1_d.first_col   = (pixel_col_i & col_mask) == '0;
    s1_d.col_zero    = pixel_col_i == '0;
    s1_d.idx         = pixel_col_i >> zoom_shift_i;
    s1_d.row         = pixel_row_i;
    s1_d.height      = channel_height_i;
    s1_d.offset      = channel_offset_i;
    s1_d.chan        = channel_number_i;
    mem_addr_d       = frame_base_q + ADDR_W'(s1_d.idx);
  end

  // RAM data arrives during S2, so the current word is used combinationally here
  // and registered for the next pixel; prev_word only advances on an index change.
  always_comb begin
    cur_word_d  = s2_q.valid ? mem_data_i : cur_word_q;
    prev_word_d = prev_word_q;
    last_idx_d  = last_idx_q;
    if (s2_q.valid) begin
      last_idx_d = s2_q.idx;
      if (s2_q.col_zero) begin
        prev_word_d = cur_word_d;
      end else if (s2_q.idx != last_idx_q) begin
        prev_word_d = cur_word_q;
      end
    end
  end

  trace_pixel_classifier #(
    .ROW_W  (ROW_W),
    .CHN_W  (CHN_W),
    .MARGIN (MARGIN)
  ) u_classifier (
    .valid_i     (s2_q.valid && s2_q.is_channel),
    .b_i         (cur_word_d[s2_q.chan]),
    .p_i         (prev_word_d[s2_q.chan]),
    .first_col_i (s2_q.first_col),
    .row_i       (s2_q.row),
    .offset_i    (s2_q.offset),
    .height_i    (s2_q.height),
    .chan_i      (s2_q.chan),
    .colour_o    (colour)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_q <= 1'b0;
      frame_base_q <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      mem_addr_q   <= '0;
      cur_word_q   <= '0;
      prev_word_q  <= '0;
      last_idx_q   <= '0;
      rgb_q        <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_i;
      if (vsync_i && !vsync_prev_q) begin
        frame_base_q <= start_addr_i;
      end
      s1_q         <= s1_d;
      mem_addr_q   <= mem_addr_d;
      s2_q         <= s1_q;
      cur_word_q   <= cur_word_d;
      prev_word_q  <= prev_word_d;
      last_idx_q   <= last_idx_d;
      rgb_q        <= COLOR_W'(colour);
      hsync_q      <= s2_q.hsync;
      vsync_q      <= s2_q.vsync;
      valid_q      <= s2_q.valid;
    end
  end

  assign mem_rd_en_o   = s1_q.valid;
  assign mem_addr_o    = mem_addr_q;
  assign rgb_o         = rgb_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign pixel_valid_o = valid_q;

endmodule
`default_nettype wire

// File: doc/waveform_renderer.md
Name: waveform_renderer

Overview:
- Pipelined pixel-colour stage directly downstream of the pixel-row-to-channel mapper in the VGA logic-analyser display.
- Takes the current pixel coordinate and that pixel's channel lane (number, height, vertical offset).
- Fetches the matching sample word from the capture RAM and outputs the RGB value of the digital trace for that pixel.
- Delays sync and active-video signals by the same number of cycles so they stay aligned with the colour.

Parameters:
- MAX_CHAN_COUNT, 10, number of channels; width of a sample word.
- ADDR_W, 10, sample RAM address width.
- H_RES, VGA_HOR_RES, visible columns.
- V_RES, VGA_VER_RES, visible rows.
- MARGIN, 4, rows between lane edge and the high/low trace line.
- COLOR_W, 12, RGB width (4:4:4).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pixel_valid  in  1  active-video strobe for this coordinate
- pixel_col  in  $clog2(H_RES)  current column
- pixel_row  in  $clog2(V_RES)  current row
- hsync_in, vsync_in  in  1 each  syncs, active high
- is_channel  in  1  row belongs to an enabled lane
- channel_number  in  $clog2(MAX_CHAN_COUNT)  channel of this lane
- channel_height  in  $clog2(V_RES)  lane height in rows
- channel_offset  in  $clog2(V_RES)  first row of the lane
- zoom_shift  in  3  columns per sample = 1<<zoom_shift
- start_addr  in  ADDR_W  first sample index of the next frame
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address
- mem_data  in  MAX_CHAN_COUNT  RAM word; valid exactly 1 cycle after mem_rd_en
- rgb  out  COLOR_W  pixel colour
- hsync_out, vsync_out, pixel_valid_out  out  1 each  delayed copies

Behaviour:
- Reset:
  - rgb=0, mem_rd_en=0, mem_addr=0, all delayed syncs/valid=0.
  - frame_base=0, prev_word=0, all pipeline registers cleared.
  - Asserting reset mid-frame takes effect immediately. The first frame after release uses frame_base=0 until the next vsync edge.
- Frame base:
  - Edge detector on vsync_in. On a 0->1 transition, frame_base<=start_addr.
  - frame_base is constant for the whole visible frame.
- Pipeline, fixed latency 3; inputs sampled at edge T:
  - S1 (T+1): register coordinate, lane info and syncs. mem_addr<=(frame_base + (pixel_col>>zoom_shift)) mod 2^ADDR_W. mem_rd_en<=pixel_valid.
  - S2 (T+2): capture mem_data into cur_word when the S1 read was enabled. prev_word holds the word of the previous sample index:
    - Update prev_word<=cur_word only when the sample index changes.
    - At pixel_col==0, force prev_word=cur_word, so no edge is drawn at the left border.
  - S3 (T+3): register rgb and the delayed hsync/vsync/pixel_valid.
- Address wrap: the sum wraps modulo 2^ADDR_W with no saturation. frame_base=2^ADDR_W-1, col 1, zoom 0 -> addr 0.
- Pixel classification (S3, b=cur_word[channel_number], p=prev_word[channel_number]):
  - hi_row=channel_offset+MARGIN.
  - lo_row=channel_offset+channel_height-1-MARGIN.
  - first_col = (pixel_col & ((1<<zoom_shift)-1))==0.
  - Trace lit if any of: (b && row==hi_row), (!b && row==lo_row), or (b!=p && first_col && hi_row<=row<=lo_row).
  - Separator: row==channel_offset && channel_number!=0 -> GRID colour. Trace has priority over separator.
- Colours: TRACE=12'h0F0, GRID=12'h444, BACKGROUND=12'h000.
- Forced BACKGROUND:
  - pixel_valid=0, or is_channel=0 -> BACKGROUND; no trace is drawn.
  - channel_height < 2*MARGIN+2 -> lane too small, BACKGROUND only.
- Width rules: compute hi_row/lo_row at $clog2(V_RES)+1 bits to avoid overflow; comparisons are unsigned.
- Simultaneous events: a vsync edge coinciding with active video is not legal VGA. If it happens anyway, the new frame_base applies from the next cycle.
- Blanking: mem_rd_en=0 while pixel_valid=0; prev_word/cur_word hold.

Decomposition:
- Shared package/header (extends vga.h): H_RES/V_RES, COLOR_W, TRACE/GRID/BACKGROUND constants, MARGIN default.
- One combinational sub-module, trace_pixel_classifier. Inputs: b, p, row, lane info, first_col, valid. Output: colour.
- The pipeline, frame-base latch and prev_word tracking stay in waveform_renderer.

Test Plan:
1. Reset: rst_n=0 mid-line with random inputs -> rgb=0, mem_rd_en=0 the same cycle. Release, then first valid pixel -> rgb appears exactly 3 cycles after the coordinate.
2. Address: start_addr=100, vsync pulse, zoom_shift=2, cols 0..7 -> mem_addr 100,100,100,100,101,101,101,101 one cycle after each column; mem_rd_en high only during pixel_valid.
3. Wrap: start_addr=1023, zoom 0, cols 0,1,2 -> addr 1023,0,1.
4. Levels: channel_offset=48, height=48, channel 1, RAM bit1=1 -> row 52 TRACE, row 91 BACKGROUND, row 48 GRID. Set bit=0 -> row 91 TRACE.
5. Edge: bit1 0->1 between samples 4 and 5, zoom 1 -> col 10 rows 52..91 TRACE, col 11 only row 52; col 0 never shows an edge even if prev frame differed.
6. Degenerate: channel_height=9 or is_channel=0 -> BACKGROUND everywhere in lane; syncs still delayed by 3.
